mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IDLE/ACCESS/RESP FSM, one transaction per three cycles.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_arbiter #(
  parameter int ADR_WIDTH  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADR_WIDTH-1:0]  addr0,
  input  logic [ADR_WIDTH-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  mem_sel,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0] mem_datain,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic [ADR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  sel_q, sel_d;
  logic                  rd_q, rd_d;
  logic                  wrStrobe_q, wrStrobe_d;
  logic                  win;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_q remembers who was served most recently; on contention the other side wins.
  logic last_q, last_d;

  always_comb begin
    win    = (req0 && req1) ? ~last_q : ~req0;
    last_d = last_q;
    if (state_q == IDLE && (req0 || req1)) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    win = ~req0;
  end
`endif

  // Strobes and acks are computed one state early so they leave the block registered.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    sel_d      = 1'b0;
    rd_d       = 1'b0;
    wrStrobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = ACCESS;
          grant_d    = win;
          wr_d       = win ? wr1 : wr0;
          addr_d     = win ? addr1 : addr0;
          wdata_d    = win ? wdata1 : wdata0;
          sel_d      = 1'b1;
          rd_d       = ~wr_d;
          wrStrobe_d = wr_d;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!wr_q) begin
          if (grant_q) begin
            rdata1_d = mem_dataout;
          end else begin
            rdata0_d = mem_dataout;
          end
        end
        ack0_d = ~grant_q;
        ack1_d = grant_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      sel_q      <= 1'b0;
      rd_q       <= 1'b0;
      wrStrobe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      wrStrobe_q <= wrStrobe_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = (state_q != IDLE);
  assign mem_sel     = sel_q;
  assign mem_rd      = rd_q;
  assign mem_wr      = wrStrobe_q;
  assign mem_address = addr_q;
  assign mem_datain  = wdata_q;

endmodule
